// File: rtl/core_pkg.sv
// Shared pipeline definitions: register-index width and the in-flight destination tag.
package core_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } tag_t;

    localparam tag_t BUBBLE_TAG = '0;

    // x0 is hard-wired, so a write to it is never a real write
    function automatic logic tag_writes(input tag_t t);
        return t.reg_write && (t.rd != '0);
    endfunction

endpackage

// File: rtl/tag_stage.sv
// One pipeline tag register; bubble takes priority over load, otherwise the tag holds.
module tag_stage
    import core_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic bubble,
    input  tag_t d,
    output tag_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BUBBLE_TAG;
        end else if (bubble) begin
            q <= BUBBLE_TAG;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destination tags across EX/MEM/WB, detects load-use and multi-cycle MUL hazards,
// and drives the front-end stall and ID/EX bubble controls.
module hazard_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = core_pkg::REG_ADDR_W,
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_is_mul,
    input  logic                  flush,
    output logic                  stall,
    output logic                  idex_bubble,
    output logic                  ex_busy,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_reg_write
);

    localparam int unsigned TAG_RD_W = core_pkg::REG_ADDR_W;
    localparam int unsigned CNT_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    tag_t             id_tag;
    tag_t             ex_tag;
    tag_t             mem_tag;
    tag_t             wb_tag;
    logic [CNT_W-1:0] mul_cnt;
    logic             out_en;

    logic             busy_i;
    logic             load_use;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             stall_i;
    logic             idex_bubble_i;
    logic             mul_accept;
    logic             ex_load;
    logic             ex_bubble;

    assign id_tag = '{rd: TAG_RD_W'(id_rd), reg_write: id_reg_write, mem_read: id_mem_read};

    // Hazard detection and pipeline-advance controls
    always_comb begin
        busy_i        = 1'b0;
        rs1_hit       = 1'b0;
        rs2_hit       = 1'b0;
        load_use      = 1'b0;
        stall_i       = 1'b0;
        idex_bubble_i = 1'b0;
        mul_accept    = 1'b0;
        ex_load       = 1'b0;
        ex_bubble     = 1'b0;

        busy_i        = (mul_cnt != '0);
        rs1_hit       = id_use_rs1 && (TAG_RD_W'(id_rs1) == ex_tag.rd);
        rs2_hit       = id_use_rs2 && (TAG_RD_W'(id_rs2) == ex_tag.rd);
        load_use      = id_valid && ex_tag.mem_read && (ex_tag.rd != '0) && (rs1_hit || rs2_hit);
        stall_i       = !flush && (load_use || busy_i);
        idex_bubble_i = flush || (load_use && !busy_i);
        ex_load       = !busy_i;
        ex_bubble     = !busy_i && (idex_bubble_i || !id_valid);
        mul_accept    = !busy_i && id_valid && id_is_mul && !idex_bubble_i;
    end

    tag_stage u_ex_stage (
        .clk    (clk),
        .rst    (rst),
        .load   (ex_load),
        .bubble (ex_bubble),
        .d      (id_tag),
        .q      (ex_tag)
    );

    // While a MUL holds EX, MEM receives bubbles instead of a duplicate of the MUL
    tag_stage u_mem_stage (
        .clk    (clk),
        .rst    (rst),
        .load   (1'b1),
        .bubble (busy_i),
        .d      (ex_tag),
        .q      (mem_tag)
    );

    tag_stage u_wb_stage (
        .clk    (clk),
        .rst    (rst),
        .load   (1'b1),
        .bubble (1'b0),
        .d      (mem_tag),
        .q      (wb_tag)
    );

    // Remaining EX occupancy of the current MUL beyond its first cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_cnt <= '0;
        end else if (busy_i) begin
            mul_cnt <= mul_cnt - CNT_W'(1);
        end else if (mul_accept && (MUL_LATENCY > 1)) begin
            mul_cnt <= CNT_W'(MUL_LATENCY - 1);
        end
    end

    // Outputs stay quiet through reset and the first cycle after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_en <= 1'b0;
        end else begin
            out_en <= 1'b1;
        end
    end

    assign stall         = out_en && stall_i;
    assign idex_bubble   = out_en && idex_bubble_i;
    assign ex_busy       = out_en && busy_i;
    assign ex_rd         = out_en ? REG_ADDR_W'(ex_tag.rd)  : '0;
    assign mem_rd        = out_en ? REG_ADDR_W'(mem_tag.rd) : '0;
    assign mem_reg_write = out_en && tag_writes(mem_tag);
    assign wb_rd         = out_en ? REG_ADDR_W'(wb_tag.rd)  : '0;
    assign wb_reg_write  = out_en && tag_writes(wb_tag);

    logic unused_tag_bits;
    assign unused_tag_bits = ^{ex_tag.reg_write, mem_tag.mem_read, wb_tag.mem_read};

endmodule
